// File: rtl/jump_key_if.sv
// jump_key_if: bundles the jump-button pin, the pending-press request and its
// frame acknowledge, plus the debounced level, miss counter and FSM state.
//
// Request handshake: jump_key is a level "valid" that, once high, stays high
// until the consumer pulses frame_ack (the "ready") for one cycle; the request
// retires on the first clock edge at which frame_ack=1 is sampled, and a new
// press accepted on that same edge re-arms it immediately.
interface jump_key_if;
    logic       key_raw;
    logic       frame_ack;
    logic       jump_key;
    logic       key_level;
    logic [7:0] missed_count;
    logic [1:0] fsm_state;

    // Board/controller side: drives the pin and the acknowledge.
    modport master (
        output key_raw,
        output frame_ack,
        input  jump_key,
        input  key_level,
        input  missed_count,
        input  fsm_state
    );

    // Conditioner side.
    modport slave (
        input  key_raw,
        input  frame_ack,
        output jump_key,
        output key_level,
        output missed_count,
        output fsm_state
    );
endinterface

// File: rtl/jump_key_conditioner.sv
// jump_key_conditioner: synchronizes and debounces the raw jump button and
// turns every accepted press into a sticky jump_key request that is held until
// the frame-rate controller acknowledges it.
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat presses while held).
module jump_key_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 15000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic        proc_clk,
    input  logic        reset,
    jump_key_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the logic cannot honour.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("jump_key_conditioner: SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1, REPEAT_CYCLES>=1 required");
    end

    logic                   k;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ks;
    state_t                 state;
    logic [DW-1:0]          cnt;
    logic                   press_evt;
    logic                   level_q;
    logic                   jump_q;
    logic [7:0]             missed_q;

`ifdef KEY_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rcnt;
`endif

    // Normalize polarity so 1 always means pressed.
    assign k  = bus.key_raw ^ (ACTIVE_LOW != 0);
    assign ks = sync[SYNC_STAGES-1];

    // Synchronizer chain; stages reset to the released level.
    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], k};
        end
    end

    // Debounce FSM with registered press event and debounced level.
    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            press_evt <= 1'b0;
            level_q   <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            rcnt      <= '0;
`endif
        end else begin
            press_evt <= 1'b0;
            level_q   <= (state == HELD) || (state == RELEASE_WAIT);
            case (state)
                IDLE: begin
                    if (ks) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!ks) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        press_evt <= 1'b1;
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!ks) begin
                        // Repeat counter is frozen, not cleared, across a
                        // release bounce so a chattering hold keeps its phase.
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef KEY_AUTO_REPEAT_EN
                    else if (rcnt == RP_LAST) begin
                        rcnt      <= '0;
                        press_evt <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (ks) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
`ifdef KEY_AUTO_REPEAT_EN
                        rcnt  <= '0;
`endif
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky request: a press sets it, an ack clears it, a same-cycle
    // ack+press leaves it set; presses landing on a pending request are counted.
    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            jump_q   <= 1'b0;
            missed_q <= 8'd0;
        end else if (press_evt) begin
            jump_q <= 1'b1;
            if (jump_q && !bus.frame_ack && (missed_q != 8'hFF)) begin
                missed_q <= missed_q + 8'd1;
            end
        end else if (bus.frame_ack) begin
            jump_q <= 1'b0;
        end
    end

    assign bus.jump_key     = jump_q;
    assign bus.key_level    = level_q;
    assign bus.missed_count = missed_q;
    assign bus.fsm_state    = state;

endmodule
